// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_pkg
// Description : Shared definitions for the approximate multiplier pipeline.
//               - params_legal: operand width / approximation depth /
//                 truncation column legality, evaluated at elaboration.
//               - approx_lo:    reference model of the approximated low
//                 partial-product rows. Operands are zero-extended to
//                 c_MAX_W bits, so any y index at or beyond the real
//                 operand width reads as 0.
// Revision    : 1.0 - initial release
// ============================================================================
package approx_mult_pkg;

    localparam int c_MAX_W   = 32;
    localparam int c_IDX_W   = $clog2(c_MAX_W);

    function automatic bit params_legal(input int w, input int l, input int t);
        return (w >= 1) && (w <= c_MAX_W) &&
               (l >= 0) && (l <= w) && ((l % 2) == 0) &&
               (t >= 0) && (t <= w + l);
    endfunction

    // Rows 2k and 2k+1 are merged into one OR-ed bit per column c >= t.
    // Each pair contributes that bit with weight 2^c; pairs are summed.
    function automatic logic [2*c_MAX_W-1:0] approx_lo(
        input logic [c_MAX_W-1:0] x,
        input logic [c_MAX_W-1:0] y,
        input int                 l,
        input int                 t
    );
        logic [2*c_MAX_W-1:0] acc;
        logic [c_IDX_W-1:0]   idx;
        logic                 b;
        acc = '0;
        for (int k = 0; k < c_MAX_W / 2; k++) begin
            if (k < l / 2) begin
                for (int c = 0; c < 2 * c_MAX_W; c++) begin
                    b = 1'b0;
                    if (c >= t) begin
                        if ((c - 2*k >= 0) && (c - 2*k < c_MAX_W)) begin
                            idx = c_IDX_W'(2*k);
                            b   = b | x[idx];
                            idx = c_IDX_W'(c - 2*k);
                            b   = b & y[idx];
                        end
                        if ((c - 2*k - 1 >= 0) && (c - 2*k - 1 < c_MAX_W)) begin
                            idx = c_IDX_W'(2*k + 1);
                            if (x[idx]) begin
                                idx = c_IDX_W'(c - 2*k - 1);
                                b   = b | y[idx];
                            end
                        end
                    end
                    if (b) begin
                        acc = acc + ((2*c_MAX_W)'(1) << c);
                    end
                end
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_mult_pipe_lo_tree.sv
`default_nettype none
// ============================================================================
// Module      : approx_lo_tree
// Description : Combinational low-part generator. Produces y * x[L-1:0]
//               when approx = 0, or the paired/truncated approximation when
//               approx = 1.
//   x, y   : operands (W bits)
//   approx : mode select
//   lo     : low-part contribution, already weighted (2W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module approx_lo_tree
    import approx_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 6,
    parameter int T = 8
)(
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           approx,
    output logic [2*W-1:0] lo
);

    generate
        if (L == 0) begin : g_no_low
            // No approximated rows: both modes contribute nothing here.
            logic w_unused;
            assign w_unused = ^{x, y, approx};
            assign lo       = '0;
        end else begin : g_low
            logic [2*W-1:0] w_exact;
            logic [2*W-1:0] w_approx;
            assign w_exact  = {{W{1'b0}}, y} * {{(2*W-L){1'b0}}, x[L-1:0]};
            assign w_approx = (2*W)'(approx_lo(c_MAX_W'(x), c_MAX_W'(y), L, T));
            assign lo       = approx ? w_approx : w_exact;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_pipe
// Description : Two-stage valid/ready unsigned multiplier with a per-
//               transaction exact/approximate mode. S1 holds the exact high
//               part H = y * x[W-1:L] and the low part LO; S2 holds
//               out_z = (H << L) + LO. Full throughput, back-pressure via
//               out_ready, tag and mode travel with the data.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake
//   in_x, in_y            : operands (W bits)
//   in_approx, in_tag     : mode bit and sideband tag
//   out_valid / out_ready : output handshake
//   out_z                 : product (2W bits)
//   out_approx, out_tag   : echoed mode and tag
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W     = 8,
    parameter int L     = 6,
    parameter int T     = 8,
    parameter int TAG_W = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_approx,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic             out_approx,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (!params_legal(W, L, T)) begin : g_illegal_params
            $error("approx_mult_pipe: illegal W/L/T (L must be even, L<=W, 0<=T<=W+L)");
        end
    endgenerate

    logic             r_s1_valid;
    logic [2*W-1:0]   r_s1_h;
    logic [2*W-1:0]   r_s1_lo;
    logic             r_s1_approx;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [2*W-1:0]   r_s2_z;
    logic             r_s2_approx;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s1_en;
    logic             w_s2_en;
    logic [2*W-1:0]   w_h;
    logic [2*W-1:0]   w_lo;
    logic [2*W-1:0]   w_sum;

    // Each stage loads when empty or when the stage after it moves, so
    // bubbles collapse and in_ready never looks at in_valid.
    assign w_s2_en  = ~r_s2_valid | out_ready;
    assign w_s1_en  = ~r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en;

    generate
        if (L == W) begin : g_no_high
            assign w_h = '0;
        end else begin : g_high
            assign w_h = {{W{1'b0}}, in_y} * {{(W+L){1'b0}}, in_x[W-1:L]};
        end
    endgenerate

    approx_lo_tree #(
        .W (W),
        .L (L),
        .T (T)
    ) u_lo_tree (
        .x      (in_x),
        .y      (in_y),
        .approx (in_approx),
        .lo     (w_lo)
    );

    // H < 2^(2W-L), so the shift cannot overflow; the approximate LO never
    // exceeds the exact one, so the sum fits 2W bits in both modes.
    assign w_sum = (r_s1_h << L) + r_s1_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_h      <= '0;
            r_s1_lo     <= '0;
            r_s1_approx <= 1'b0;
            r_s1_tag    <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_h      <= w_h;
                r_s1_lo     <= w_lo;
                r_s1_approx <= in_approx;
                r_s1_tag    <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_z      <= '0;
            r_s2_approx <= 1'b0;
            r_s2_tag    <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_z      <= w_sum;
                r_s2_approx <= r_s1_approx;
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_z      = r_s2_z;
    assign out_approx = r_s2_approx;
    assign out_tag    = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_mult_pipe
// Description : Scoreboard bench. Stimulus pushes expected results into a
//               queue at acceptance; per-DUT monitors pop and compare on
//               every output transfer. Covers W=8/L=6/T=8 plus the
//               W=16/L=8/T=16 and W=8/L=0/T=0 configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;
    import approx_mult_pkg::*;

    typedef struct packed {
        logic [31:0] z;
        logic        a;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q0[$];
    exp_t e8, e16, e0;

    // ---------------- main DUT: W=8, L=6, T=8 ----------------
    logic        in_valid, in_ready, in_approx;
    logic [7:0]  in_x, in_y;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready, out_approx;
    logic [15:0] out_z;

    approx_mult_pipe #(.W(8), .L(6), .T(8), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_approx(in_approx), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_approx(out_approx), .out_tag(out_tag)
    );

    // ---------------- sweep DUT: W=16, L=8, T=16 ----------------
    logic        s16_valid, s16_ready, s16_approx, s16_ovalid, s16_oapprox;
    logic [15:0] s16_x, s16_y;
    logic [3:0]  s16_tag, s16_otag;
    logic [31:0] s16_z;

    approx_mult_pipe #(.W(16), .L(8), .T(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(s16_valid), .in_ready(s16_ready),
        .in_x(s16_x), .in_y(s16_y), .in_approx(s16_approx), .in_tag(s16_tag),
        .out_valid(s16_ovalid), .out_ready(1'b1),
        .out_z(s16_z), .out_approx(s16_oapprox), .out_tag(s16_otag)
    );

    // ---------------- sweep DUT: W=8, L=0, T=0 ----------------
    logic        s0_valid, s0_ready, s0_approx, s0_ovalid, s0_oapprox;
    logic [7:0]  s0_x, s0_y;
    logic [3:0]  s0_tag, s0_otag;
    logic [15:0] s0_z;

    approx_mult_pipe #(.W(8), .L(0), .T(0), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(s0_valid), .in_ready(s0_ready),
        .in_x(s0_x), .in_y(s0_y), .in_approx(s0_approx), .in_tag(s0_tag),
        .out_valid(s0_ovalid), .out_ready(1'b1),
        .out_z(s0_z), .out_approx(s0_oapprox), .out_tag(s0_otag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int l, input int t,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic a);
        logic [63:0] h, lo, ex;
        h  = 64'(y) * 64'(x >> l);
        lo = approx_lo(x, y, l, t);
        ex = 64'(x) * 64'(y);
        return a ? 32'((h << l) + lo) : 32'(ex);
    endfunction

    // Presents one transaction and holds it until accepted.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic a,
                        input logic [3:0] tag, input logic [15:0] ez, input bit track);
        in_valid = 1'b1; in_x = x; in_y = y; in_approx = a; in_tag = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (track) q8.push_back('{z: 32'(ez), a: a, tag: tag});
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic a,
                          input logic [3:0] tag, input logic [31:0] ez);
        s16_valid = 1'b1; s16_x = x; s16_y = y; s16_approx = a; s16_tag = tag;
        @(negedge clk);
        check("sw16_in_ready", 64'(s16_ready), 64'd1);
        q16.push_back('{z: ez, a: a, tag: tag});
        @(posedge clk); #1;
        s16_valid = 1'b0;
    endtask

    task automatic send0(input logic [7:0] x, input logic [7:0] y, input logic a,
                         input logic [3:0] tag, input logic [15:0] ez);
        s0_valid = 1'b1; s0_x = x; s0_y = y; s0_approx = a; s0_tag = tag;
        @(negedge clk);
        check("sw0_in_ready", 64'(s0_ready), 64'd1);
        q0.push_back('{z: 32'(ez), a: a, tag: tag});
        @(posedge clk); #1;
        s0_valid = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL main_unexpected: tag %0d z %0d emitted, expected no output", out_tag, out_z);
            end else begin
                e8 = q8.pop_front();
                check("main_z", 64'(out_z), 64'(e8.z));
                check("main_approx", 64'(out_approx), 64'(e8.a));
                check("main_tag", 64'(out_tag), 64'(e8.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s16_ovalid) begin
            if (q16.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sw16_unexpected: tag %0d emitted, expected no output", s16_otag);
            end else begin
                e16 = q16.pop_front();
                check("sw16_z", 64'(s16_z), 64'(e16.z));
                check("sw16_approx", 64'(s16_oapprox), 64'(e16.a));
                check("sw16_tag", 64'(s16_otag), 64'(e16.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s0_ovalid) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sw0_unexpected: tag %0d emitted, expected no output", s0_otag);
            end else begin
                e0 = q0.pop_front();
                check("sw0_z", 64'(s0_z), 64'(e0.z));
                check("sw0_approx", 64'(s0_oapprox), 64'(e0.a));
                check("sw0_tag", 64'(s0_otag), 64'(e0.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          t0;
        logic [7:0]  rx, ry;
        logic        ra;
        logic [15:0] wx, wy;

        rst = 1'b1;
        in_valid = 0; in_x = 0; in_y = 0; in_approx = 0; in_tag = 0; out_ready = 1'b1;
        s16_valid = 0; s16_x = 0; s16_y = 0; s16_approx = 0; s16_tag = 0;
        s0_valid = 0;  s0_x = 0;  s0_y = 0;  s0_approx = 0;  s0_tag = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_z", 64'(out_z), 64'd0);
        check("reset_out_approx", 64'(out_approx), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted at edge E, visible after edge E+1.
        send(8'd255, 8'd255, 1'b1, 4'd1, 16'd58944, 1'b1);
        in_valid = 1'b0;
        check("latency_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Directed vectors, back to back.
        send(8'd255, 8'd255, 1'b0, 4'd2, 16'd65025, 1'b1);
        send(8'd3,   8'd128, 1'b1, 4'd3, 16'd256,   1'b1);
        send(8'd3,   8'd128, 1'b0, 4'd4, 16'd384,   1'b1);
        send(8'd64,  8'd3,   1'b1, 4'd5, 16'd192,   1'b1);
        send(8'd64,  8'd3,   1'b0, 4'd6, 16'd192,   1'b1);
        send(8'd0,   8'd255, 1'b1, 4'd7, 16'd0,     1'b1);
        send(8'd255, 8'd1,   1'b1, 4'd8, 16'd192,   1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Stream of 20, one accepted per cycle.
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); ra = 1'($urandom_range(0, 1));
            send(rx, ry, ra, 4'(i), 16'(model(6, 8, 32'(rx), 32'(ry), ra)), 1'b1);
        end
        check("stream_cycles", 64'(cyc - t0), 64'd20);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("stream_drained", 64'(q8.size()), 64'd0);

        // Back-pressure: 3 offered, 2 fit, outputs held.
        out_ready = 1'b0;
        fork
            begin
                send(8'd10, 8'd20, 1'b0, 4'd5, 16'd200, 1'b1);
                send(8'd255, 8'd1, 1'b1, 4'd6, 16'd192, 1'b1);
                send(8'd12, 8'd11, 1'b0, 4'd7, 16'd132, 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk); #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_out_tag", 64'(out_tag), 64'd5);
                repeat (5) begin
                    @(posedge clk); #2;
                    check("stall_z_held", 64'(out_z), 64'd200);
                    check("stall_tag_held", 64'(out_tag), 64'd5);
                    check("stall_full", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        check("stall_drained", 64'(q8.size()), 64'd0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(8'd7, 8'd9, 1'b0, 4'd8, 16'd63, 1'b0);
        send(8'd200, 8'd100, 1'b1, 4'd9, 16'd0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_z", 64'(out_z), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        // Input offered while rst is high on an empty pipe must be dropped.
        in_valid = 1'b1; in_x = 8'd5; in_y = 8'd5; in_tag = 4'd10; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_no_output", 64'(out_valid), 64'd0);
        end

        // W=16, L=8, T=16.
        send16(16'hFF00, 16'hFFFF, 1'b1, 4'd1, 32'hFEFF0100);
        send16(16'd3, 16'h8000, 1'b1, 4'd2, 32'd65536);
        send16(16'd3, 16'h8000, 1'b0, 4'd3, 32'd98304);
        for (int i = 0; i < 10; i++) begin
            wx = 16'($urandom); wy = 16'($urandom); ra = 1'($urandom_range(0, 1));
            send16(wx, wy, ra, 4'(i), model(8, 16, 32'(wx), 32'(wy), ra));
        end

        // W=8, L=0: approx must equal exact.
        send0(8'd255, 8'd255, 1'b1, 4'd1, 16'd65025);
        for (int i = 0; i < 10; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); ra = 1'($urandom_range(0, 1));
            send0(rx, ry, ra, 4'(i), 16'(rx) * 16'(ry));
        end

        repeat (5) @(posedge clk); #1;
        check("final_q8_empty", 64'(q8.size()), 64'd0);
        check("final_q16_empty", 64'(q16.size()), 64'd0);
        check("final_q0_empty", 64'(q0.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
